// File: rtl/fpu_mem_request_engine_if.sv
// Memory request/response channel between the FPU memory request engine and memory.
// One in-order valid/ready request path plus an in-order read-response path.
interface fpu_mem_request_engine_if #(
  parameter int BEAT_BYTES = 64
);
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_we;
  logic [31:0]             mem_req_addr;
  logic [8*BEAT_BYTES-1:0] mem_req_data;
  logic [BEAT_BYTES-1:0]   mem_req_be;
  logic                    mem_rsp_valid;
  logic [8*BEAT_BYTES-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_data, mem_req_be,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_data, mem_req_be,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/fpu_mem_request_engine.sv
// Tile read / result write engine between the FPU controller and memory.
// Optional perf counters are enabled with the FPU_MEM_REQ_PERF_EN macro.
module fpu_mem_request_engine #(
  parameter int COL_WIDTH        = 10,
  parameter int MEM_BUFFER_WIDTH = 512,
  parameter int BEAT_BYTES       = 64,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      request_read,
  input  logic [31:0]                               read_address,
  input  logic                                      request_write,
  input  logic [31:0]                               write_address,
  input  logic [16:0]                               write_request_size,
  input  logic [17:0]                               row_stride,
  output logic                                      making_request,
  fpu_mem_request_engine_if.master                  mem,
  output logic                                      fb_wr_en,
  output logic [$clog2(COL_WIDTH)-1:0]              fb_wr_row,
  output logic [$clog2(MEM_BUFFER_WIDTH/BEAT_BYTES)-1:0] fb_wr_beat,
  output logic [8*BEAT_BYTES-1:0]                   fb_wr_data,
  output logic                                      wb_rd_en,
  output logic [$clog2(COL_WIDTH)-1:0]              wb_rd_row,
  output logic [$clog2(MEM_BUFFER_WIDTH/BEAT_BYTES)-1:0] wb_rd_beat,
  input  logic [8*BEAT_BYTES-1:0]                   wb_rd_data,
`ifdef FPU_MEM_REQ_PERF_EN
  output logic [31:0]                               perf_busy_cycles,
  output logic [31:0]                               perf_stall_cycles,
`endif
  output logic                                      err_overlap
);
  localparam int BEATS = MEM_BUFFER_WIDTH / BEAT_BYTES;
  localparam int RW    = $clog2(COL_WIDTH);
  localparam int BW    = $clog2(BEATS);
  localparam int NW    = $clog2(BEATS + 1);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int SH    = $clog2(BEAT_BYTES);
  localparam int DW    = 8 * BEAT_BYTES;

  typedef enum logic [2:0] {IDLE, WR_FETCH, WR_SEND, RD_ISSUE, RD_DRAIN} state_t;
  state_t state, nxt;

  logic                  rd_pend, wr_loaded;
  logic [31:0]           rd_addr_q, row_base;
  logic [17:0]           stride_q;
  logic [NW-1:0]         wr_nbeats;
  logic [BEAT_BYTES-1:0] last_be;
  logic [RW-1:0]         req_row, rsp_row;
  logic [BW-1:0]         req_beat, rsp_beat;
  logic [OW-1:0]         outst;
  logic [DW-1:0]         wdata_q;

  logic [16:0]           size_c;
  logic [SH-1:0]         rem;
  logic [NW-1:0]         nbeats_in;
  logic [BEAT_BYTES-1:0] be_in;
  logic [31:0]           beat_addr;
  logic beat_last, row_last, xfer_last, issue_ok, req_fire, rsp_acc, rsp_last, iss;
  state_t wr_next;

  // Clamp the row size, then derive beat count and the partial mask of the row's last beat.
  always_comb begin
    size_c    = (write_request_size > 17'(MEM_BUFFER_WIDTH)) ? 17'(MEM_BUFFER_WIDTH)
                                                             : write_request_size;
    rem       = size_c[SH-1:0];
    nbeats_in = NW'((size_c + 17'(BEAT_BYTES - 1)) >> SH);
    for (int i = 0; i < BEAT_BYTES; i++) be_in[i] = (rem == '0) || (SH'(i) < rem);
  end

  assign beat_addr = row_base + (32'(req_beat) << SH);
  assign beat_last = (state == RD_ISSUE) ? (req_beat == BW'(BEATS - 1))
                                         : (NW'(req_beat) == wr_nbeats - NW'(1));
  assign row_last  = (state == RD_ISSUE) ? (req_row == RW'(COL_WIDTH - 1))
                                         : (req_row == RW'(COL_WIDTH - 3));
  assign xfer_last = beat_last && row_last;
  assign issue_ok  = outst < OW'(MAX_OUTSTANDING);
  assign req_fire  = mem.mem_req_valid && mem.mem_req_ready;
  assign iss       = req_fire && (state == RD_ISSUE);
  // Responses with nothing outstanding are stale (e.g. from before a reset) and dropped.
  assign rsp_acc   = mem.mem_rsp_valid && (outst != '0);
  assign rsp_last  = (rsp_row == RW'(COL_WIDTH - 1)) && (rsp_beat == BW'(BEATS - 1));
  assign wr_next   = rd_pend ? RD_ISSUE : IDLE;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (request_write) nxt = WR_FETCH;
                else if (request_read) nxt = RD_ISSUE;
      WR_FETCH: nxt = (wr_nbeats == '0) ? wr_next : WR_SEND;
      WR_SEND:  if (req_fire) nxt = xfer_last ? wr_next : WR_FETCH;
      RD_ISSUE: if (req_fire && xfer_last) nxt = RD_DRAIN;
      RD_DRAIN: if (rsp_acc && rsp_last) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_comb begin
    making_request    = (state != IDLE);
    mem.mem_req_valid = 1'b0;
    mem.mem_req_we    = 1'b0;
    mem.mem_req_addr  = '0;
    mem.mem_req_data  = '0;
    mem.mem_req_be    = '0;
    wb_rd_en          = 1'b0;
    wb_rd_row         = '0;
    wb_rd_beat        = '0;
    fb_wr_en          = rsp_acc;
    fb_wr_row         = rsp_acc ? rsp_row : '0;
    fb_wr_beat        = rsp_acc ? rsp_beat : '0;
    fb_wr_data        = rsp_acc ? mem.mem_rsp_data : '0;
    case (state)
      WR_FETCH: if (wr_nbeats != '0) begin
        wb_rd_en   = 1'b1;
        wb_rd_row  = req_row;
        wb_rd_beat = req_beat;
      end
      WR_SEND: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_we    = 1'b1;
        mem.mem_req_addr  = beat_addr;
        // Buffer data arrives in the first send cycle; hold our copy while stalled.
        mem.mem_req_data  = wr_loaded ? wdata_q : wb_rd_data;
        mem.mem_req_be    = beat_last ? last_be : '1;
      end
      RD_ISSUE: if (issue_ok) begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = beat_addr;
        mem.mem_req_be    = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0; wr_loaded <= 1'b0; err_overlap <= 1'b0;
      rd_addr_q <= '0; row_base <= '0; stride_q <= '0; wr_nbeats <= '0; last_be <= '0;
      req_row <= '0; req_beat <= '0; rsp_row <= '0; rsp_beat <= '0;
      outst <= '0; wdata_q <= '0;
    end else begin
      if (state != IDLE && (request_read || request_write)) err_overlap <= 1'b1;
      if (state == IDLE) begin
        if (request_read || request_write) begin
          rd_pend   <= request_read && request_write;
          rd_addr_q <= read_address;
          stride_q  <= row_stride;
          wr_nbeats <= request_write ? nbeats_in : '0;
          last_be   <= be_in;
          row_base  <= request_write ? write_address : read_address;
          req_row   <= '0;
          req_beat  <= '0;
        end
      end else if (nxt == RD_ISSUE && state != RD_ISSUE) begin
        rd_pend  <= 1'b0;
        row_base <= rd_addr_q;
        req_row  <= '0;
        req_beat <= '0;
      end else if (req_fire) begin
        if (beat_last) begin
          req_beat <= '0;
          req_row  <= req_row + RW'(1);
          row_base <= row_base + 32'(stride_q);
        end else req_beat <= req_beat + BW'(1);
      end
      if (state == WR_SEND) begin
        wr_loaded <= 1'b1;
        if (!wr_loaded) wdata_q <= wb_rd_data;
      end else wr_loaded <= 1'b0;
      outst <= outst + OW'(iss) - OW'(rsp_acc);
      if (rsp_acc) begin
        if (rsp_last) begin
          rsp_row <= '0; rsp_beat <= '0;
        end else if (rsp_beat == BW'(BEATS - 1)) begin
          rsp_beat <= '0; rsp_row <= rsp_row + RW'(1);
        end else rsp_beat <= rsp_beat + BW'(1);
      end
    end
  end

`ifdef FPU_MEM_REQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (making_request && perf_busy_cycles != '1) perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if (mem.mem_req_valid && !mem.mem_req_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fpu_mem_request_engine.sv
// Scoreboard bench for fpu_mem_request_engine: directed transfers, memory and write-buffer models.
module tb_fpu_mem_request_engine;
  localparam int COLW = 10, BEATS = 8, BB = 64, DW = 512, MAXO = 4;
  typedef logic [DW-1:0] w_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [DW-1:0] data; logic [BB-1:0] be; } req_t;
  typedef struct packed { logic [3:0] row; logic [2:0] beat; logic [DW-1:0] data; } fb_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        request_read = 0, request_write = 0;
  logic [31:0] read_address = 0, write_address = 0;
  logic [16:0] write_request_size = 0;
  logic [17:0] row_stride = 0;
  logic        making_request, fb_wr_en, wb_rd_en, err_overlap;
  logic [3:0]  fb_wr_row, wb_rd_row;
  logic [2:0]  fb_wr_beat, wb_rd_beat;
  logic [DW-1:0] fb_wr_data, wb_rd_data = '0;
`ifdef FPU_MEM_REQ_PERF_EN
  logic [31:0] perf_busy_cycles, perf_stall_cycles;
`endif

  fpu_mem_request_engine_if #(.BEAT_BYTES(BB)) mem_if ();

  fpu_mem_request_engine dut (
    .clk(clk), .rst_n(rst_n),
    .request_read(request_read), .read_address(read_address),
    .request_write(request_write), .write_address(write_address),
    .write_request_size(write_request_size), .row_stride(row_stride),
    .making_request(making_request), .mem(mem_if),
    .fb_wr_en(fb_wr_en), .fb_wr_row(fb_wr_row), .fb_wr_beat(fb_wr_beat), .fb_wr_data(fb_wr_data),
    .wb_rd_en(wb_rd_en), .wb_rd_row(wb_rd_row), .wb_rd_beat(wb_rd_beat), .wb_rd_data(wb_rd_data),
`ifdef FPU_MEM_REQ_PERF_EN
    .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles),
`endif
    .err_overlap(err_overlap)
  );

  req_t exp_req[$];
  fb_t  exp_fb[$];
  logic [31:0] seen_addr[$];
  logic [BB-1:0] seen_be[$];
  logic [31:0] pend_addr[$];
  int   pend_due[$];
  int   checks = 0, passes = 0, cyc = 0, lat = 2, outst = 0, max_out = 0, last_fb_cyc = 0;
  logic stray = 0, wb_pend = 0, stall_prev = 0;
  logic [3:0] wb_r;
  logic [2:0] wb_b;
  logic [31:0] stall_addr;
  req_t e;
  fb_t  f;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, w_t act, w_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic w_t rdata(logic [31:0] a);
    return {16{a ^ 32'h5A5A_0000}};
  endfunction
  function automatic w_t wbdata(logic [3:0] r, logic [2:0] b);
    return {16{32'hA000_0000 | (32'(r) << 8) | 32'(b)}};
  endfunction

  task automatic push_read(logic [31:0] base, int stride);
    for (int r = 0; r < COLW; r++)
      for (int b = 0; b < BEATS; b++) begin
        req_t q; fb_t fq;
        q.we = 0; q.addr = base + 32'(r * stride) + 32'(b * BB); q.data = '0; q.be = '1;
        exp_req.push_back(q);
        fq.row = 4'(r); fq.beat = 3'(b); fq.data = rdata(q.addr);
        exp_fb.push_back(fq);
      end
  endtask

  task automatic push_write(logic [31:0] base, int size, int stride);
    int sz, nb, rem;
    sz = (size > 512) ? 512 : size; nb = (sz + BB - 1) / BB; rem = sz % BB;
    for (int r = 0; r < COLW - 2; r++)
      for (int b = 0; b < nb; b++) begin
        req_t q;
        q.we = 1; q.addr = base + 32'(r * stride) + 32'(b * BB); q.data = wbdata(4'(r), 3'(b));
        q.be = (b == nb - 1 && rem != 0) ? (64'(1) << rem) - 64'(1) : '1;
        exp_req.push_back(q);
      end
  endtask

  task automatic pulse(logic rd, logic wr, logic [31:0] ra, logic [31:0] wa, int sz, int stride);
    @(posedge clk); #1;
    request_read = rd; request_write = wr; read_address = ra; write_address = wa;
    write_request_size = 17'(sz); row_stride = 18'(stride);
    @(posedge clk); #1;
    request_read = 0; request_write = 0;
  endtask

  task automatic wait_idle(int budget, output int n, output int fall);
    bit done = 0;
    n = 0; fall = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!making_request) begin done = 1; fall = cyc; end else n++;
    end
    if (!done) check("idle_timeout", w_t'(making_request), '0);
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_ctl"}, w_t'({making_request, mem_if.mem_req_valid, mem_if.mem_req_we,
                               fb_wr_en, wb_rd_en, err_overlap}), '0);
    check({tag, "_addr"}, w_t'(mem_if.mem_req_addr), '0);
    check({tag, "_data"}, mem_if.mem_req_data, '0);
    check({tag, "_be"}, w_t'(mem_if.mem_req_be), '0);
    check({tag, "_fbdata"}, fb_wr_data, '0);
    check({tag, "_idx"}, w_t'({fb_wr_row, fb_wr_beat, wb_rd_row, wb_rd_beat}), '0);
  endtask

  task automatic chk_drained(string tag, int nbeats);
    check({tag, "_req_left"}, w_t'(exp_req.size()), '0);
    check({tag, "_fb_left"}, w_t'(exp_fb.size()), '0);
    check({tag, "_nbeats"}, w_t'(seen_addr.size()), w_t'(nbeats));
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a transaction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        check("bp_valid", w_t'(mem_if.mem_req_valid), w_t'(1));
        check("bp_addr", w_t'(mem_if.mem_req_addr), w_t'(stall_addr));
      end
      stall_prev = mem_if.mem_req_valid && !mem_if.mem_req_ready;
      stall_addr = mem_if.mem_req_addr;
      if (mem_if.mem_req_valid && mem_if.mem_req_ready) begin
        seen_addr.push_back(mem_if.mem_req_addr);
        seen_be.push_back(mem_if.mem_req_be);
        check("req_expected", w_t'(exp_req.size() > 0), w_t'(1));
        if (exp_req.size() > 0) begin
          e = exp_req.pop_front();
          check("req_we", w_t'(mem_if.mem_req_we), w_t'(e.we));
          check("req_addr", w_t'(mem_if.mem_req_addr), w_t'(e.addr));
          check("req_be", w_t'(mem_if.mem_req_be), w_t'(e.be));
          check("req_data", mem_if.mem_req_data, e.data);
        end
        if (!mem_if.mem_req_we) begin
          pend_addr.push_back(mem_if.mem_req_addr);
          pend_due.push_back(cyc + lat);
          outst++;
        end
      end
      if (fb_wr_en) begin
        check("fb_expected", w_t'(exp_fb.size() > 0), w_t'(1));
        if (exp_fb.size() > 0) begin
          f = exp_fb.pop_front();
          check("fb_pos", w_t'({fb_wr_row, fb_wr_beat}), w_t'({f.row, f.beat}));
          check("fb_data", fb_wr_data, f.data);
        end
        outst--;
        last_fb_cyc = cyc;
      end
      if (outst > max_out) max_out = outst;
      if (wb_rd_en) begin wb_pend = 1; wb_r = wb_rd_row; wb_b = wb_rd_beat; end
    end
  end

  // Memory and write-buffer responders, driven just after each rising edge.
  initial forever begin
    @(posedge clk); #1;
    if (!rst_n) begin
      mem_if.mem_rsp_valid = 0; mem_if.mem_rsp_data = '0; wb_pend = 0;
    end else begin
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        mem_if.mem_rsp_valid = 1;
        mem_if.mem_rsp_data  = rdata(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        mem_if.mem_rsp_valid = stray;
        mem_if.mem_rsp_data  = stray ? '1 : '0;
      end
      if (wb_pend) begin wb_rd_data = wbdata(wb_r, wb_b); wb_pend = 0; end
    end
  end

  initial begin
    int n, fall;
    mem_if.mem_req_ready = 1; mem_if.mem_rsp_valid = 0; mem_if.mem_rsp_data = '0;
    repeat (3) @(posedge clk); #1;
    chk_zero("reset");
    rst_n = 1;

    // Tile read, 2-cycle response latency.
    seen_addr.delete(); push_read(32'h1000_0200, 1542);
    pulse(1, 0, 32'h1000_0200, 0, 0, 1542);
    wait_idle(400, n, fall);
    chk_drained("rd", 80);
    check("rd_beat9_addr", w_t'(seen_addr[8]), w_t'(32'h1000_0806));
    check("rd_fall", w_t'(fall), w_t'(last_fb_cyc + 1));

    // Result write, 300-byte rows: 5 beats/row, 44-byte tail.
    seen_addr.delete(); seen_be.delete(); push_write(32'h1000_4000, 300, 1542);
    pulse(0, 1, 0, 32'h1000_4000, 300, 1542);
    wait_idle(400, n, fall);
    chk_drained("wr", 40);
    check("wr_row1_addr", w_t'(seen_addr[5]), w_t'(32'h1000_4606));
    check("wr_tail_be", w_t'(seen_be[4]), w_t'(64'h0000_0FFF_FFFF_FFFF));
    check("wr_full_be", w_t'(seen_be[3]), w_t'(64'hFFFF_FFFF_FFFF_FFFF));

    // Simultaneous pulses: clamped write first, then a read that wraps the address space.
    seen_addr.delete();
    push_write(32'h2000_0000, 600, 512); push_read(32'hFFFF_FF00, 32'h200);
    pulse(1, 1, 32'hFFFF_FF00, 32'h2000_0000, 600, 32'h200);
    wait_idle(800, n, fall);
    chk_drained("both", 144);
    check("both_wrap_addr", w_t'(seen_addr[64 + 72]), w_t'(32'h0000_1100));

    // Long latency plus 5 cycles of backpressure mid-read.
    lat = 6; max_out = 0; seen_addr.delete(); push_read(32'h3000_0000, 640);
    pulse(1, 0, 32'h3000_0000, 0, 0, 640);
    repeat (12) @(posedge clk); #1; mem_if.mem_req_ready = 0;
    repeat (5) @(posedge clk); #1; mem_if.mem_req_ready = 1;
    wait_idle(800, n, fall);
    chk_drained("bp", 80);
    check("bp_max_outstanding", w_t'(max_out), w_t'(MAXO));

    // Overlapping pulse is ignored and flagged.
    lat = 2; seen_addr.delete(); push_read(32'h4000_0000, 1024);
    pulse(1, 0, 32'h4000_0000, 0, 0, 1024);
    repeat (6) @(posedge clk);
    pulse(1, 0, 32'h5000_0000, 0, 0, 1024);
    @(negedge clk); check("ovl_err", w_t'(err_overlap), w_t'(1));
    wait_idle(400, n, fall);
    repeat (5) @(negedge clk);
    chk_drained("ovl", 80);

    // Stray response while idle must not touch the fill buffer.
    @(posedge clk); stray = 1;
    @(negedge clk); check("stray_fb", w_t'(fb_wr_en), '0);
    @(posedge clk); stray = 0;

    // Zero-size write: busy for exactly one cycle, no requests.
    seen_addr.delete();
    pulse(0, 1, 0, 32'h6000_0000, 0, 64);
    wait_idle(20, n, fall);
    check("sz0_busy", w_t'(n), w_t'(1));
    check("sz0_reqs", w_t'(seen_addr.size()), '0);
    check("err_sticky", w_t'(err_overlap), w_t'(1));

    // Reset in the middle of a write.
    push_write(32'h7000_0000, 300, 1542);
    pulse(0, 1, 0, 32'h7000_0000, 300, 1542);
    repeat (8) @(posedge clk); #1;
    rst_n = 0; #1;
    chk_zero("midrst");
    exp_req.delete(); exp_fb.delete(); pend_addr.delete(); pend_due.delete();
    outst = 0; stall_prev = 0;
    repeat (2) @(posedge clk); #1; rst_n = 1;
    repeat (3) @(negedge clk);
    chk_zero("postrst");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
